// File: rtl/cpu_bus_if.sv
// System-bus side of the CPU bus sequencer: address, strobes and data, plus the optional wait line.
// bus_wait exists only when CPU_BUS_WAIT_EN is defined.
interface cpu_bus_if;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
`ifdef CPU_BUS_WAIT_EN
    logic        bus_wait;
`endif

    modport master (
        output bus_addr,
        output bus_rd,
        output bus_wr,
        output bus_wdata,
`ifdef CPU_BUS_WAIT_EN
        input  bus_wait,
`endif
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_rd,
        input  bus_wr,
        input  bus_wdata,
`ifdef CPU_BUS_WAIT_EN
        output bus_wait,
`endif
        output bus_rdata
    );
endinterface

// File: rtl/cpu_bus_interface.sv
// CPU memory bus sequencer: T-cycle generator (T0..T3), M-cycle address mux, rd/wr strobes, read capture.
// Latency: address/strobes 1 clk after T0 starts, read data in T3 (3 clks after T0 starts).
// Backpressure: with CPU_BUS_WAIT_EN defined, bus_wait stalls T2; otherwise T2 is always one clk.
module cpu_bus_interface (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [2:0]  mem_addr_sel,
    input  logic [15:0] inc_addr,
    input  logic [15:0] pc,
    input  logic [15:0] reg_pair,
    input  logic [7:0]  reg_c,
    input  logic [7:0]  wdata_in,
    output logic [1:0]  t_cycle,
    output logic        mcycle_end,
    output logic [7:0]  mem_data_in,
    cpu_bus_if.master   bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstate_t;

    localparam logic [2:0] SEL_INC     = 3'd0;
    localparam logic [2:0] SEL_PC      = 3'd1;
    localparam logic [2:0] SEL_REGPAIR = 3'd2;
    localparam logic [2:0] SEL_HIGHC   = 3'd3;
    localparam logic [2:0] SEL_HIGHIMM = 3'd4;

    tstate_t     state;
    tstate_t     state_nxt;
    logic        stall;
    logic [7:0]  imm;
    logic [15:0] addr_mux;

`ifdef CPU_BUS_WAIT_EN
    // Wait is only honoured in T2; other phases ignore it.
    assign stall = (state == T2) && bus.bus_wait;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            T0:      state_nxt = T1;
            T1:      state_nxt = T2;
            T2:      state_nxt = stall ? T2 : T3;
            T3:      state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= state_nxt;
        end
    end

    assign t_cycle    = state;
    assign mcycle_end = (state == T3);

    always_comb begin
        addr_mux = 16'h0000;
        case (mem_addr_sel)
            SEL_INC:     addr_mux = inc_addr;
            SEL_PC:      addr_mux = pc;
            SEL_REGPAIR: addr_mux = reg_pair;
            SEL_HIGHC:   addr_mux = {8'hFF, reg_c};
            SEL_HIGHIMM: addr_mux = {8'hFF, imm};
            default:     addr_mux = 16'h0000;
        endcase
    end

    // Address and write data only move on memory M-cycles; idle cycles keep the bus quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bus_addr  <= 16'h0000;
            bus.bus_wdata <= 8'h00;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            mem_data_in   <= 8'h00;
            imm           <= 8'h00;
        end else begin
            case (state)
                T0: begin
                    if (mem_enable) begin
                        bus.bus_addr  <= addr_mux;
                        bus.bus_wdata <= wdata_in;
                        bus.bus_rd    <= !mem_write;
                        bus.bus_wr    <= mem_write;
                    end
                end
                T2: begin
                    if (!stall) begin
                        bus.bus_rd <= 1'b0;
                        bus.bus_wr <= 1'b0;
                        if (bus.bus_rd) begin
                            mem_data_in <= bus.bus_rdata;
                            imm         <= bus.bus_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
